// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester-side and ALU-side signals for alu_share_arbiter.
// slave = arbiter view; master = requesters plus the ALU instance.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [2:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_zero;

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, alu_result, alu_zero,
    output req_ready, alu_op, alu_a, alu_b, resp_valid, resp_result, resp_zero
  );

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, alu_result, alu_zero,
    input  req_ready, alu_op, alu_a, alu_b, resp_valid, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU; MUL holds the ALU for MUL_CYCLES.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic           clk,
  input logic           reset,
  alu_share_arbiter_if.slave io_bus
);
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StExec  = 1'b1;
  localparam logic [2:0] OpMul   = 3'b111;
  localparam logic [3:0] CntLast = 4'(MUL_CYCLES - 1);

  logic [0:0]            r_state;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_owner;
  logic [3:0]            r_cnt;
  logic [1:0]            r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_result;
  logic                  r_resp_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                  r_last;
`endif

  logic       w_done;
  logic       w_exec_done;
  logic       w_can_accept;
  logic [1:0] w_grant;
  logic       w_hs;

  always_comb begin
    w_done       = (r_op != OpMul) || (r_cnt == CntLast);
    w_exec_done  = (r_state == StExec) && w_done;
    w_can_accept = (r_state == StIdle) || w_exec_done;
    w_grant      = 2'b00;
    if (w_can_accept) begin
      unique case (io_bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
        2'b11:   w_grant = 2'b01;
`else
        // Contention: the requester that did not win last time goes first.
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
`endif
        default: w_grant = 2'b00;
      endcase
    end
    w_hs = |w_grant;
  end

  assign io_bus.req_ready   = w_grant;
  assign io_bus.alu_op      = (r_state == StExec) ? r_op : 3'b000;
  assign io_bus.alu_a       = (r_state == StExec) ? r_a : '0;
  assign io_bus.alu_b       = (r_state == StExec) ? r_b : '0;
  assign io_bus.resp_valid  = r_resp_valid;
  assign io_bus.resp_result = r_resp_result;
  assign io_bus.resp_zero   = r_resp_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_op          <= 3'b000;
      r_a           <= '0;
      r_b           <= '0;
      r_owner       <= 1'b0;
      r_cnt         <= 4'd0;
      r_resp_valid  <= 2'b00;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_last        <= 1'b1;
`endif
    end else begin
      r_resp_valid <= 2'b00;
      if (w_exec_done) begin
        r_resp_valid[r_owner] <= 1'b1;
        r_resp_result         <= io_bus.alu_result;
        r_resp_zero           <= io_bus.alu_zero;
      end
      if (w_hs) begin
        r_op    <= w_grant[1] ? io_bus.req1_op : io_bus.req0_op;
        r_a     <= w_grant[1] ? io_bus.req1_a  : io_bus.req0_a;
        r_b     <= w_grant[1] ? io_bus.req1_b  : io_bus.req0_b;
        r_owner <= w_grant[1];
        r_cnt   <= 4'd0;
        r_state <= StExec;
`ifndef ALU_ARB_FIXED_PRIO_EN
        r_last  <= w_grant[1];
`endif
      end else if (w_exec_done) begin
        r_state <= StIdle;
      end else if (r_state == StExec) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench for alu_share_arbiter with a behavioural ALU model on the ALU side.
module tb_alu_share_arbiter;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] MUL = 3'b111;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  ready;
    logic [1:0]  rvalid;
    logic        chk_res;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_share_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_share_arbiter #(
    .DATA_WIDTH(32),
    .MUL_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Reference ALU the arbiter drives.
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_op)
      3'b000: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a + bus.alu_b;
      3'b011: bus.alu_result = bus.alu_a - bus.alu_b;
      3'b100: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      3'b101: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      3'b110: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: bus.alu_result = bus.alu_a * bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  function automatic vec_t mk(logic rst, logic [1:0] valid,
                              logic [2:0] op0, logic [31:0] a0, logic [31:0] b0,
                              logic [2:0] op1, logic [31:0] a1, logic [31:0] b1,
                              logic [1:0] ready, logic [1:0] rvalid, logic chk_res,
                              logic [31:0] result, logic zero,
                              logic [2:0] alu_op, logic [31:0] alu_a);
    vec_t v;
    v.rst = rst;     v.valid = valid;
    v.op0 = op0;     v.a0 = a0;         v.b0 = b0;
    v.op1 = op1;     v.a1 = a1;         v.b1 = b1;
    v.ready = ready; v.rvalid = rvalid; v.chk_res = chk_res;
    v.result = result; v.zero = zero;
    v.alu_op = alu_op; v.alu_a = alu_a;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Inputs applied just after the rising edge, outputs checked on the falling edge.
  task automatic step(string tag, int idx, vec_t v);
    reset         = v.rst;
    bus.req_valid = v.valid;
    bus.req0_op   = v.op0;
    bus.req0_a    = v.a0;
    bus.req0_b    = v.b0;
    bus.req1_op   = v.op1;
    bus.req1_a    = v.a1;
    bus.req1_b    = v.b1;
    @(negedge clk);
    chk($sformatf("%s[%0d] req_ready", tag, idx), {30'd0, bus.req_ready}, {30'd0, v.ready});
    chk($sformatf("%s[%0d] resp_valid", tag, idx), {30'd0, bus.resp_valid}, {30'd0, v.rvalid});
    chk($sformatf("%s[%0d] alu_op", tag, idx), {29'd0, bus.alu_op}, {29'd0, v.alu_op});
    chk($sformatf("%s[%0d] alu_a", tag, idx), bus.alu_a, v.alu_a);
    if (v.chk_res) begin
      chk($sformatf("%s[%0d] resp_result", tag, idx), bus.resp_result, v.result);
      chk($sformatf("%s[%0d] resp_zero", tag, idx), {31'd0, bus.resp_zero}, {31'd0, v.zero});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    // Reset check, single ADD, SUB with zero flag, then round-robin contention.
    tbl[0]  = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b00, 1, 0, 0,  0, 0);
    tbl[1]  = mk(0, 2'b01, ADD, 5, 7,   0, 0, 0,       2'b01, 2'b00, 0, 0, 0,  0, 0);
    tbl[2]  = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b00, 0, 0, 0,  ADD, 5);
    tbl[3]  = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b01, 1, 12, 0, 0, 0);
    tbl[4]  = mk(0, 2'b10, 0, 0, 0,     SUB, 9, 9,     2'b10, 2'b00, 0, 0, 0,  0, 0);
    tbl[5]  = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b00, 0, 0, 0,  SUB, 9);
    tbl[6]  = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b10, 1, 0, 1,  0, 0);
    tbl[7]  = mk(0, 2'b11, ADD, 1, 1,   ADD, 10, 10,   2'b01, 2'b00, 0, 0, 0,  0, 0);
    tbl[8]  = mk(0, 2'b11, ADD, 2, 2,   ADD, 10, 10,   2'b10, 2'b00, 0, 0, 0,  ADD, 1);
    tbl[9]  = mk(0, 2'b11, ADD, 2, 2,   ADD, 20, 20,   2'b01, 2'b01, 1, 2, 0,  ADD, 10);
    tbl[10] = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b10, 1, 20, 0, ADD, 2);
    tbl[11] = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b01, 1, 4, 0,  0, 0);
    tbl[12] = mk(0, 2'b00, 0, 0, 0,     0, 0, 0,       2'b00, 2'b00, 0, 0, 0,  0, 0);

    bus.req_valid = 2'b00;
    bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) step("tbl", i, tbl[i]);

    // MUL holds the ALU four cycles; req1 waits and is granted in the done cycle.
    step("mul", 0, mk(0, 2'b01, MUL, 6, 7, 0, 0, 0,   2'b01, 2'b00, 0, 0, 0,  0, 0));
    step("mul", 1, mk(0, 2'b10, 0, 0, 0,  ADD, 3, 4,  2'b00, 2'b00, 0, 0, 0,  MUL, 6));
    step("mul", 2, mk(0, 2'b10, 0, 0, 0,  ADD, 3, 4,  2'b00, 2'b00, 0, 0, 0,  MUL, 6));
    step("mul", 3, mk(0, 2'b10, 0, 0, 0,  ADD, 3, 4,  2'b00, 2'b00, 0, 0, 0,  MUL, 6));
    step("mul", 4, mk(0, 2'b10, 0, 0, 0,  ADD, 3, 4,  2'b10, 2'b00, 0, 0, 0,  MUL, 6));
    step("mul", 5, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b01, 1, 42, 0, ADD, 3));
    step("mul", 6, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b10, 1, 7, 0,  0, 0));

    // Reset two cycles into a MUL from req0: no response, outputs cleared, req0 wins next.
    step("rst", 0, mk(0, 2'b01, MUL, 6, 7, 0, 0, 0,   2'b01, 2'b00, 0, 0, 0,  0, 0));
    step("rst", 1, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 0, 0, 0,  MUL, 6));
    step("rst", 2, mk(1, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 0, 0, 0,  MUL, 6));
    step("rst", 3, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 1, 0, 0,  0, 0));
    step("rst", 4, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 0, 0, 0,  0, 0));
    step("rst", 5, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 1, 0, 0,  0, 0));
    step("rst", 6, mk(0, 2'b11, ADD, 1, 2, ADD, 3, 4, 2'b01, 2'b00, 0, 0, 0,  0, 0));
    step("rst", 7, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b00, 0, 0, 0,  ADD, 1));
    step("rst", 8, mk(0, 2'b00, 0, 0, 0,  0, 0, 0,    2'b00, 2'b01, 1, 3, 0,  0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
